// File: rtl/me_window_buffer.sv
// Motion-estimation window buffer.
// Holds one MACRO_DIM x MACRO_DIM current macroblock and one SEARCH_DIM x SEARCH_DIM
// search window, both loaded from a single raster pixel stream, and serves column reads.
//
// Ports:
//   clk, rst          single clock, synchronous active-high reset
//   load_start        pulse; begins loading macroblock then search window
//   in_valid/in_pixel load stream; in_ready high while a load is in progress
//   buf_ready         both memories loaded, reads permitted
//   rd_en/rd_addr     read request and word address into all banks
//   rd_amt            rotation applied to the search-bank read lanes
//   pixel_cpr_out     MACRO_DIM current-bank bytes (lane l at [l*8 +: 8])
//   pixel_spr_out     MACRO_DIM+1 rotated search-bank bytes
//   rd_valid          read data valid, one cycle after an accepted rd_en
module me_window_buffer #(
  parameter int unsigned MACRO_DIM  = 16,
  parameter int unsigned SEARCH_DIM = 48
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         load_start,
  input  logic                         in_valid,
  input  logic [7:0]                   in_pixel,
  output logic                         in_ready,
  output logic                         buf_ready,
  input  logic                         rd_en,
  input  logic [7:0]                   rd_addr,
  input  logic [5:0]                   rd_amt,
  output logic [MACRO_DIM*8-1:0]       pixel_cpr_out,
  output logic [(MACRO_DIM+1)*8-1:0]   pixel_spr_out,
  output logic                         rd_valid
);

  localparam int unsigned PortWidth = MACRO_DIM + 1;
  localparam int unsigned Sdepth    = SEARCH_DIM * (SEARCH_DIM / MACRO_DIM);
  localparam int unsigned NumSeg    = (SEARCH_DIM + PortWidth - 1) / PortWidth;
  localparam int unsigned CntW      = $clog2(SEARCH_DIM);
  localparam int unsigned BankW     = $clog2(PortWidth);
  localparam int unsigned SegW      = (NumSeg > 1) ? $clog2(NumSeg) : 1;
  localparam int unsigned CurWords  = MACRO_DIM * MACRO_DIM;
  localparam int unsigned CurAw     = $clog2(CurWords);
  localparam int unsigned SrchWords = PortWidth * Sdepth;
  localparam int unsigned SrchAw    = $clog2(SrchWords);

  typedef enum logic [1:0] {StIdle, StLoadCur, StLoadSrch, StReady} state_e;

  state_e state_q, state_d;
  logic [CntW-1:0]  row_q, row_d, col_q, col_d;
  // Search column split as bank = col mod PortWidth, seg = col div PortWidth, tracked
  // incrementally so no divider sits on the write path.
  logic [BankW-1:0] bank_q, bank_d;
  logic [SegW-1:0]  seg_q, seg_d;

  // Flattened bank memories: current bank c word r at c*MACRO_DIM + r,
  // search bank b word a at b*Sdepth + a. Not reset; only overwritten by transfers.
  logic [7:0] cur_mem  [CurWords];
  logic [7:0] srch_mem [SrchWords];

  logic [CurAw-1:0]  cur_waddr;
  logic [SrchAw-1:0] srch_waddr;

  logic                     rd_valid_q;
  logic [MACRO_DIM*8-1:0]   cpr_q, cpr_d;
  logic [PortWidth*8-1:0]   spr_q, spr_d;

  assign in_ready      = (state_q == StLoadCur) || (state_q == StLoadSrch);
  assign buf_ready     = (state_q == StReady);
  assign rd_valid      = rd_valid_q;
  assign pixel_cpr_out = cpr_q;
  assign pixel_spr_out = spr_q;

  // Next-state and load counters
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    bank_d  = bank_q;
    seg_d   = seg_q;
    unique case (state_q)
      StIdle, StReady: begin
        if (load_start) begin
          state_d = StLoadCur;
          row_d   = '0;
          col_d   = '0;
          bank_d  = '0;
          seg_d   = '0;
        end
      end
      StLoadCur: begin
        if (in_valid) begin
          if (col_q == CntW'(MACRO_DIM - 1)) begin
            col_d = '0;
            if (row_q == CntW'(MACRO_DIM - 1)) begin
              row_d   = '0;
              state_d = StLoadSrch;
            end else begin
              row_d = row_q + CntW'(1);
            end
          end else begin
            col_d = col_q + CntW'(1);
          end
        end
      end
      StLoadSrch: begin
        if (in_valid) begin
          if (col_q == CntW'(SEARCH_DIM - 1)) begin
            col_d  = '0;
            bank_d = '0;
            seg_d  = '0;
            if (row_q == CntW'(SEARCH_DIM - 1)) begin
              row_d   = '0;
              state_d = StReady;
            end else begin
              row_d = row_q + CntW'(1);
            end
          end else begin
            col_d = col_q + CntW'(1);
            if (bank_q == BankW'(PortWidth - 1)) begin
              bank_d = '0;
              seg_d  = seg_q + SegW'(1);
            end else begin
              bank_d = bank_q + BankW'(1);
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      row_q   <= '0;
      col_q   <= '0;
      bank_q  <= '0;
      seg_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      bank_q  <= bank_d;
      seg_q   <= seg_d;
    end
  end

  // Write addresses
  always_comb begin
    cur_waddr  = CurAw'(32'(col_q) * MACRO_DIM + 32'(row_q));
    srch_waddr = SrchAw'(32'(bank_q) * Sdepth + 32'(seg_q) * SEARCH_DIM + 32'(row_q));
  end

  always_ff @(posedge clk) begin
    if (!rst && in_valid && (state_q == StLoadCur)) begin
      cur_mem[cur_waddr] <= in_pixel;
    end
    if (!rst && in_valid && (state_q == StLoadSrch)) begin
      srch_mem[srch_waddr] <= in_pixel;
    end
  end

  // Read path: lane l of the search port reads bank (l + rd_amt) mod PortWidth.
  // rd_addr / SEARCH_DIM is the segment, which fixes the window column of each bank.
  always_comb begin
    int unsigned amt;
    int unsigned seg;
    cpr_d = '0;
    spr_d = '0;
    amt   = 32'(rd_amt) % PortWidth;
    seg   = 32'(rd_addr) / SEARCH_DIM;
    for (int unsigned l = 0; l < MACRO_DIM; l++) begin
      if (32'(rd_addr) < MACRO_DIM) begin
        cpr_d[l*8 +: 8] = cur_mem[CurAw'(l * MACRO_DIM + 32'(rd_addr))];
      end
    end
    for (int unsigned l = 0; l < PortWidth; l++) begin
      int unsigned bank;
      bank = l + amt;
      if (bank >= PortWidth) begin
        bank = bank - PortWidth;
      end
      if ((32'(rd_addr) < Sdepth) && (seg * PortWidth + bank < SEARCH_DIM)) begin
        spr_d[l*8 +: 8] = srch_mem[SrchAw'(bank * Sdepth + 32'(rd_addr))];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      cpr_q      <= '0;
      spr_q      <= '0;
    end else if (rd_en && (state_q == StReady)) begin
      rd_valid_q <= 1'b1;
      cpr_q      <= cpr_d;
      spr_q      <= spr_d;
    end else begin
      rd_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_me_window_buffer.sv
// Scoreboard bench for me_window_buffer at default parameters.
module tb_me_window_buffer;

  localparam int MD = 16;
  localparam int SD = 48;
  localparam int PW = 17;
  localparam int NPIX = MD * MD + SD * SD;

  logic              clk = 1'b0;
  logic              rst, load_start, in_valid, in_ready, buf_ready;
  logic [7:0]        in_pixel, rd_addr;
  logic [5:0]        rd_amt;
  logic              rd_en, rd_valid;
  logic [MD*8-1:0]   pixel_cpr_out;
  logic [PW*8-1:0]   pixel_spr_out;

  always #5 clk = ~clk;

  me_window_buffer #(.MACRO_DIM(MD), .SEARCH_DIM(SD)) dut (
    .clk           (clk),
    .rst           (rst),
    .load_start    (load_start),
    .in_valid      (in_valid),
    .in_pixel      (in_pixel),
    .in_ready      (in_ready),
    .buf_ready     (buf_ready),
    .rd_en         (rd_en),
    .rd_addr       (rd_addr),
    .rd_amt        (rd_amt),
    .pixel_cpr_out (pixel_cpr_out),
    .pixel_spr_out (pixel_spr_out),
    .rd_valid      (rd_valid)
  );

  typedef struct {
    logic [MD*8-1:0] cpr;
    logic [PW*8-1:0] spr;
  } rd_t;

  rd_t exp_q[$];
  rd_t held;
  int  total = 0;
  int  bad   = 0;
  bit  mon_on = 1'b0;
  logic rst_at_edge = 1'b0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] cur_pat(input int p, input int r, input int c);
    if (p == 0) return 8'(r * 16 + c);
    if (p == 1) return 8'(r * 7 + c * 3 + 1);
    return 8'(r * 13 + c * 5 + 9);
  endfunction

  function automatic logic [7:0] srch_pat(input int p, input int r, input int c);
    if (p == 0) return 8'(c);
    if (p == 1) return 8'(r * 5 + c * 11 + 3);
    return 8'(r * 3 + c + 100);
  endfunction

  function automatic logic [7:0] pix(input int p, input int idx);
    if (idx < MD * MD) return cur_pat(p, idx / MD, idx % MD);
    return srch_pat(p, (idx - MD * MD) / SD, (idx - MD * MD) % SD);
  endfunction

  // Expected read: current lane l = pixel (addr, l); search lane l reads window column
  // seg*17 + ((l + amt) mod 17), row addr mod 48.
  task automatic model_read(input int p, input int addr, input int amt, output rd_t e);
    int a, seg, row, b, col;
    e.cpr = '0;
    e.spr = '0;
    a = amt % PW;
    seg = addr / SD;
    row = addr % SD;
    for (int l = 0; l < MD; l++) begin
      if (addr < MD) e.cpr[l*8 +: 8] = cur_pat(p, addr, l);
    end
    for (int l = 0; l < PW; l++) begin
      b = (l + a) % PW;
      col = seg * PW + b;
      if (addr < SD * (SD / MD) && col < SD) e.spr[l*8 +: 8] = srch_pat(p, row, col);
    end
  endtask

  always @(posedge clk) rst_at_edge <= rst;

  // Monitor: pops on rd_valid, otherwise outputs must hold (or be 0 after reset).
  always @(negedge clk) begin
    rd_t e;
    if (mon_on) begin
      if (rst_at_edge) begin
        held.cpr = '0;
        held.spr = '0;
        check("reset_rd_valid", rd_valid, 0);
        check("reset_cpr", pixel_cpr_out, 0);
        check("reset_spr", pixel_spr_out, 0);
      end else if (rd_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rd_valid", rd_valid, 0);
        end else begin
          e = exp_q.pop_front();
          check("read_cpr", pixel_cpr_out, e.cpr);
          check("read_spr", pixel_spr_out, e.spr);
          held = e;
        end
      end else begin
        check("hold_cpr", pixel_cpr_out, held.cpr);
        check("hold_spr", pixel_spr_out, held.spr);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input int addr, input int amt, input rd_t e);
    rd_en = 1'b1;
    rd_addr = 8'(addr);
    rd_amt = 6'(amt);
    exp_q.push_back(e);
    tick();
    rd_en = 1'b0;
    @(negedge clk);
    check("rd_latency_valid", rd_valid, 1);
    tick();
    @(negedge clk);
    check("rd_valid_drops", rd_valid, 0);
  endtask

  task automatic model_rd(input int p, input int addr, input int amt);
    rd_t e;
    model_read(p, addr, amt, e);
    do_read(addr, amt, e);
  endtask

  // Streams one full load. abort_at >= 0 resets the DUT when that many transfers are done.
  task automatic do_load(input int p, input bit toggle, input int abort_at, input int ls_at,
                         input bit rd_during, input int exp_cycles);
    int  idx = 0;
    int  cyc = 0;
    int  ir_low = 0;
    int  br_high = 0;
    bit  pulsed = 1'b0;
    bit  xfer;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    check("load_buf_ready_drop", buf_ready, 0);
    check("load_in_ready", in_ready, 1);
    while (idx < NPIX && cyc < 12000) begin
      in_valid = toggle ? (cyc % 2 == 0) : 1'b1;
      in_pixel = pix(p, idx);
      rd_en = rd_during;
      rd_addr = 8'(idx);
      rd_amt = 6'(idx);
      load_start = (ls_at >= 0 && idx == ls_at && !pulsed);
      if (load_start) pulsed = 1'b1;
      if (!in_ready) ir_low++;
      if (buf_ready) br_high++;
      xfer = in_valid && in_ready;
      if (abort_at >= 0 && idx == abort_at) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        load_start = 1'b0;
        check("abort_in_ready", in_ready, 0);
        check("abort_buf_ready", buf_ready, 0);
        repeat (6) tick();
        check("abort_idle_in_ready", in_ready, 0);
        check("abort_idle_buf_ready", buf_ready, 0);
        in_valid = 1'b0;
        rd_en = 1'b0;
        return;
      end
      tick();
      cyc++;
      if (xfer) idx++;
    end
    in_valid = 1'b0;
    rd_en = 1'b0;
    load_start = 1'b0;
    check("load_transfers", idx, NPIX);
    check("load_in_ready_gaps", ir_low, 0);
    check("load_early_buf_ready", br_high, 0);
    check("load_done_buf_ready", buf_ready, 1);
    check("load_done_in_ready", in_ready, 0);
    if (exp_cycles > 0) check("load_cycles", cyc, exp_cycles);
  endtask

  initial begin
    rd_t e;
    rst = 1'b1;
    load_start = 1'b0;
    in_valid = 1'b0;
    in_pixel = '0;
    rd_en = 1'b0;
    rd_addr = '0;
    rd_amt = '0;
    held.cpr = '0;
    held.spr = '0;
    repeat (2) tick();
    mon_on = 1'b1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_buf_ready", buf_ready, 0);
    rst = 1'b0;
    tick();
    check("idle_in_ready", in_ready, 0);

    // Full-rate load with the reference patterns
    do_load(0, 1'b0, -1, -1, 1'b0, NPIX);

    for (int l = 0; l < MD; l++) e.cpr[l*8 +: 8] = 8'(80 + l);
    for (int l = 0; l < PW; l++) e.spr[l*8 +: 8] = 8'(l);
    do_read(5, 0, e);
    e.cpr = '0;
    for (int l = 0; l < PW; l++) e.spr[l*8 +: 8] = 8'(17 + ((l + 3) % 17));
    do_read(48, 3, e);
    do_read(48, 20, e);
    for (int l = 0; l < PW; l++) e.spr[l*8 +: 8] = (l < 14) ? 8'(34 + l) : 8'(0);
    do_read(96, 0, e);
    e.spr = '0;
    do_read(150, 0, e);
    repeat (3) tick();
    model_rd(0, 15, 16);
    model_rd(0, 16, 1);
    model_rd(0, 143, 0);

    // Half-rate load with reads requested throughout
    do_load(1, 1'b1, -1, -1, 1'b1, 2 * NPIX - 1);
    model_rd(1, 0, 0);
    model_rd(1, 7, 5);
    model_rd(1, 15, 63);
    model_rd(1, 47, 1);
    model_rd(1, 60, 9);
    model_rd(1, 100, 30);
    model_rd(1, 143, 2);
    model_rd(1, 200, 0);

    // Reset mid search-load with rd_en held high
    do_load(2, 1'b0, MD * MD + 100, -1, 1'b1, 0);
    // Reload; a load_start pulse mid-stream must be ignored
    do_load(2, 1'b0, -1, 1000, 1'b0, NPIX);
    model_rd(2, 3, 0);
    model_rd(2, 12, 11);
    model_rd(2, 33, 16);
    model_rd(2, 70, 4);
    model_rd(2, 130, 17);

    // Reset dominates load_start, in_valid and rd_en
    rst = 1'b1;
    load_start = 1'b1;
    in_valid = 1'b1;
    rd_en = 1'b1;
    rd_addr = 8'd3;
    tick();
    check("dom_in_ready", in_ready, 0);
    check("dom_buf_ready", buf_ready, 0);
    rst = 1'b0;
    load_start = 1'b0;
    in_valid = 1'b0;
    rd_en = 1'b0;
    repeat (2) tick();
    check("dom_idle_in_ready", in_ready, 0);
    check("dom_idle_buf_ready", buf_ready, 0);
    check("scoreboard_drained", exp_q.size(), 0);

    @(negedge clk);
    mon_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
